gap_layer_mc: RTL and testbench
===============================

// Module: gap_layer_mc
// PURPOSE
//  Multi-channel global-average-pooling layer; parametrised successor of the single-channel GAP stage.
//  Consumes a channel-interleaved stream (t0:c0..cN-1, t1:c0..) of INPUT_SIZE samples per channel.
//  Emits one fixed-point average per channel, serially, to the dense/classifier stage.
//  Division uses a constant reciprocal multiply; valid/ready handshake on both sides.
// PARAMETERS
//  INPUT_SIZE    5   samples per channel per frame (>=1)
//  NUM_CHANNELS  1   interleaved channels (>=1)
//  WORD_SIZE     16  signed data width, in and out
//  N_SIZE        12  fractional bits of data (format tag only; averaging is scale-invariant)
//  RECIP_BITS    16  precision of reciprocal: RECIP = round(2^RECIP_BITS / INPUT_SIZE)
// PORTS
//  clk_i      in   1                    clock, all state on posedge
//  reset_i    in   1                    synchronous, active-high reset
//  valid_i    in   1                    upstream sample valid
//  ready_o    out  1                    high in eACC; sample taken when valid_i & ready_o
//  data_r_i   in   WORD_SIZE            signed input sample
//  valid_o    out  1                    average valid (eOUT)
//  ready_i    in   1                    downstream accepts when valid_o & ready_i
//  data_r_o   out  WORD_SIZE            signed channel average, registered
//  channel_o  out  max(1,clog2(NUM_CHANNELS))  channel index of data_r_o
// BEHAVIOUR
//  Reset: state eACC, ready_o=1, valid_o=0, data_r_o=0, channel_o=0, accumulators/counters=0.
//  ACC_W = WORD_SIZE + clog2(INPUT_SIZE); one signed ACC_W accumulator per channel.
//  eACC: each accepted sample adds into acc[ch_cnt]; ch_cnt wraps 0..NUM_CHANNELS-1, then samp_cnt++.
//  Last sample (samp_cnt=INPUT_SIZE-1, ch_cnt=NUM_CHANNELS-1) accepted at edge k -> eOUT;
//   data_r_o=avg(acc[0]), channel_o=0, valid_o=1 visible after edge k; ready_o=0 after edge k.
//  avg(a) = (a*RECIP + 2^(RECIP_BITS-1)) >>> RECIP_BITS (signed product, round-half-up, floor shift).
//  eOUT: data_r_o/channel_o held stable while valid_o & !ready_i.
//   On accept of channel c<NUM_CHANNELS-1: next edge loads avg(acc[c+1]); one output per cycle sustained.
//   On accept of last channel: -> eACC, valid_o=0, ready_o=1, all accumulators and counters cleared.
//  Inputs ignored in eOUT (ready_o=0); no frame overlap, no double buffering.
//  valid_i dropped mid-frame: counters hold, accumulation resumes on next accepted sample.
//  reset_i mid-frame or mid-drain: returns to reset values next edge; partial frame discarded.
//  Result narrowing to WORD_SIZE per CONFIGURATION.
// CONFIGURATION
//  GAP_SATURATE_EN defined: avg clamped to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1] before register.
//  GAP_SATURATE_EN undefined: avg truncated to low WORD_SIZE bits (two's-complement wrap).
//  Only differs when reciprocal rounding pushes a full-scale average one LSB out of range.
// TESTING
//  T1 NC=1,IS=5: five x 16'h1000, ready_i=1 -> one output 16'h1000, channel_o=0, valid_o 1 cycle.
//  T2 NC=1,IS=5: five x 16'hF000 -> 16'hF000 (floor shift of -268398592 gives -4096).
//  T3 NC=2,IS=5: alternate 16'h1000/16'hF000 x5 -> 16'h1000 ch0, then 16'hF000 ch1 next cycle.
//  T4 backpressure: T3 with ready_i=0 for 4 cycles -> valid_o=1, data/channel stable, ready_o=0;
//     release -> both outputs drain, ready_o=1 the cycle after ch1 accept.
//  T5 IS=6: six x 16'h7FFF (RECIP=10923, raw 32768) -> 16'h7FFF with GAP_SATURATE_EN, 16'h8000 without.
//  T6 reset_i pulse after 3 of 5 samples, then full T1 frame -> output 16'h1000 (no stale sum);
//     valid_i gaps mid-frame -> same result.

Source files
------------

// File: rtl/gap_layer_mc.sv
// gap_layer_mc: multi-channel global average pooling over a channel-interleaved sample stream.
// Build option GAP_SATURATE_EN clamps each average to the WORD_SIZE range instead of wrapping it.
module gap_layer_mc #(
  parameter int INPUT_SIZE   = 5,
  parameter int NUM_CHANNELS = 1,
  parameter int WORD_SIZE    = 16,
  parameter int N_SIZE       = 12,
  parameter int RECIP_BITS   = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WORD_SIZE-1:0] data_r_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [WORD_SIZE-1:0] data_r_o,
  output logic [(NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1)-1:0] channel_o
);

  localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int SAMP_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int ACC_W  = WORD_SIZE + $clog2(INPUT_SIZE);
  localparam int PROD_W = ACC_W + RECIP_BITS + 2;

  localparam longint RECIP = ((longint'(1) << RECIP_BITS) + INPUT_SIZE / 2) / INPUT_SIZE;
  localparam logic signed [RECIP_BITS+1:0] RECIP_S = (RECIP_BITS + 2)'(RECIP);
  localparam logic signed [PROD_W-1:0] ROUND_S = PROD_W'(longint'(1) << (RECIP_BITS - 1));

  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CHANNELS - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(INPUT_SIZE - 1);

  if (INPUT_SIZE < 1 || NUM_CHANNELS < 1 || N_SIZE < 0 || N_SIZE >= WORD_SIZE) begin : g_bad_cfg
    $error("gap_layer_mc: illegal parameter combination");
  end

  typedef enum logic {eACC, eOUT} state_e;

  state_e                  state_q;
  logic signed [ACC_W-1:0] acc_q [NUM_CHANNELS];
  logic signed [ACC_W-1:0] acc_d [NUM_CHANNELS];
  logic [CH_W-1:0]         ch_cnt_q;
  logic [SAMP_W-1:0]       samp_cnt_q;
  logic [CH_W-1:0]         out_ch_q;
  logic [CH_W-1:0]         next_ch;
  logic [WORD_SIZE-1:0]    data_q;
  logic                    valid_q;
  logic                    ready_q;
  logic signed [ACC_W-1:0] sample_ext;
  logic                    accept_in;
  logic                    last_sample;

  // Reciprocal multiply, round half up, floor shift, then narrow to WORD_SIZE.
  function automatic logic [WORD_SIZE-1:0] avg_fn(input logic signed [ACC_W-1:0] a);
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
`ifdef GAP_SATURATE_EN
    logic signed [PROD_W-1:0] sat_max;
    logic signed [PROD_W-1:0] sat_min;
`endif
    prod    = PROD_W'(a) * PROD_W'(RECIP_S) + ROUND_S;
    shifted = prod >>> RECIP_BITS;
`ifdef GAP_SATURATE_EN
    sat_max = PROD_W'((longint'(1) << (WORD_SIZE - 1)) - 1);
    sat_min = ~sat_max;
    if (shifted > sat_max) shifted = sat_max;
    else if (shifted < sat_min) shifted = sat_min;
`endif
    return shifted[WORD_SIZE-1:0];
  endfunction

  assign sample_ext  = ACC_W'($signed(data_r_i));
  assign accept_in   = valid_i & ready_q;
  assign last_sample = (ch_cnt_q == CH_LAST) && (samp_cnt_q == SAMP_LAST);
  assign next_ch     = (out_ch_q == CH_LAST) ? out_ch_q : out_ch_q + 1'b1;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) acc_d[i] = acc_q[i];
    if (accept_in) acc_d[ch_cnt_q] = acc_q[ch_cnt_q] + sample_ext;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= eACC;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      data_q     <= '0;
      out_ch_q   <= '0;
      ch_cnt_q   <= '0;
      samp_cnt_q <= '0;
      // NOTE: the accumulator array is reset explicitly; a partial frame must never leak through.
      for (int i = 0; i < NUM_CHANNELS; i++) acc_q[i] <= '0;
    end else begin
      case (state_q)
        eACC: begin
          if (accept_in) begin
            for (int i = 0; i < NUM_CHANNELS; i++) acc_q[i] <= acc_d[i];
            if (ch_cnt_q == CH_LAST) begin
              ch_cnt_q   <= '0;
              samp_cnt_q <= (samp_cnt_q == SAMP_LAST) ? '0 : samp_cnt_q + 1'b1;
            end else begin
              ch_cnt_q <= ch_cnt_q + 1'b1;
            end
            // acc_d[0] already holds the final sample when NUM_CHANNELS is 1.
            if (last_sample) begin
              state_q  <= eOUT;
              ready_q  <= 1'b0;
              valid_q  <= 1'b1;
              data_q   <= avg_fn(acc_d[0]);
              out_ch_q <= '0;
            end
          end
        end
        eOUT: begin
          if (ready_i) begin
            if (out_ch_q == CH_LAST) begin
              state_q    <= eACC;
              ready_q    <= 1'b1;
              valid_q    <= 1'b0;
              out_ch_q   <= '0;
              ch_cnt_q   <= '0;
              samp_cnt_q <= '0;
              for (int i = 0; i < NUM_CHANNELS; i++) acc_q[i] <= '0;
            end else begin
              out_ch_q <= next_ch;
              data_q   <= avg_fn(acc_q[next_ch]);
            end
          end
        end
        default: state_q <= eACC;
      endcase
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = valid_q;
  assign data_r_o  = data_q;
  assign channel_o = out_ch_q;

endmodule

// File: tb/tb_gap_layer_mc.sv
// Directed bench for gap_layer_mc: three instances cover 1 channel/5 samples,
// 2 channels/5 samples and 1 channel/6 samples (the full-scale rounding corner).
module tb_gap_layer_mc;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic        ready_i;
  logic [15:0] data_i;

  logic        r1, v1, r2, v2, r6, v6;
  logic [15:0] d1, d2, d6;
  logic [0:0]  c1, c2, c6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gap_layer_mc #(.INPUT_SIZE(5), .NUM_CHANNELS(1)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(r1), .data_r_i(data_i),
    .valid_o(v1), .ready_i(ready_i), .data_r_o(d1), .channel_o(c1));

  gap_layer_mc #(.INPUT_SIZE(5), .NUM_CHANNELS(2)) dut2 (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(r2), .data_r_i(data_i),
    .valid_o(v2), .ready_i(ready_i), .data_r_o(d2), .channel_o(c2));

  gap_layer_mc #(.INPUT_SIZE(6), .NUM_CHANNELS(1)) dut6 (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(r6), .data_r_i(data_i),
    .valid_o(v6), .ready_i(ready_i), .data_r_o(d6), .channel_o(c6));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    valid_i = 1'b0;
    tick();
    reset_i = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    valid_i = 1'b1;
    data_i  = d;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({r1, v1, c1, d1} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_dut1: got r=%b v=%b c=%h d=%h want r=1 v=0 c=0 d=0000", r1, v1, c1, d1);
    end
    checks++;
    if ({r2, v2, c2, d2} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_dut2: got r=%b v=%b c=%h d=%h want r=1 v=0 c=0 d=0000", r2, v2, c2, d2);
    end
  endtask

  // Five equal samples on the single-channel instance; output lasts one cycle.
  task automatic test_single(input string name, input logic [15:0] s, input logic [15:0] exp);
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) send(s);
    checks++;
    if ({v1, r1, c1, d1} !== {1'b1, 1'b0, 1'b0, exp}) begin
      errors++;
      $display("FAIL %s_out: got v=%b r=%b c=%h d=%h want v=1 r=0 c=0 d=%h", name, v1, r1, c1, d1, exp);
    end
    tick();
    checks++;
    if ({v1, r1} !== 2'b01) begin
      errors++;
      $display("FAIL %s_drain: got v=%b r=%b want v=0 r=1", name, v1, r1);
    end
  endtask

  // Non-multiple sums exercise round-half-up and the floor shift.
  task automatic test_rounding();
    logic [15:0] pos [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000};
    logic [15:0] neg [5] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) send(pos[i]);
    checks++;
    if ({v1, d1} !== {1'b1, 16'h0001}) begin
      errors++;
      $display("FAIL round_pos: got v=%b d=%h want v=1 d=0001", v1, d1);
    end
    tick();
    for (int i = 0; i < 5; i++) send(neg[i]);
    checks++;
    if ({v1, d1} !== {1'b1, 16'hFFFF}) begin
      errors++;
      $display("FAIL round_neg: got v=%b d=%h want v=1 d=ffff", v1, d1);
    end
    tick();
  endtask

  task automatic send_two_ch(input logic [15:0] a [5], input logic [15:0] b [5]);
    for (int i = 0; i < 5; i++) begin
      send(a[i]);
      send(b[i]);
    end
  endtask

  task automatic test_two_channel();
    logic [15:0] a [5] = '{default: 16'h1000};
    logic [15:0] b [5] = '{default: 16'hF000};
    do_reset();
    ready_i = 1'b1;
    send_two_ch(a, b);
    checks++;
    if ({v2, r2, c2, d2} !== {1'b1, 1'b0, 1'b0, 16'h1000}) begin
      errors++;
      $display("FAIL two_ch0: got v=%b r=%b c=%h d=%h want v=1 r=0 c=0 d=1000", v2, r2, c2, d2);
    end
    tick();
    checks++;
    if ({v2, c2, d2} !== {1'b1, 1'b1, 16'hF000}) begin
      errors++;
      $display("FAIL two_ch1: got v=%b c=%h d=%h want v=1 c=1 d=f000", v2, c2, d2);
    end
    tick();
    checks++;
    if ({v2, r2} !== 2'b01) begin
      errors++;
      $display("FAIL two_done: got v=%b r=%b want v=0 r=1", v2, r2);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] a [5] = '{default: 16'h1000};
    logic [15:0] b [5] = '{default: 16'hF000};
    do_reset();
    ready_i = 1'b0;
    send_two_ch(a, b);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({v2, r2, c2, d2} !== {1'b1, 1'b0, 1'b0, 16'h1000}) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b r=%b c=%h d=%h want v=1 r=0 c=0 d=1000", i, v2, r2, c2, d2);
      end
      tick();
    end
    ready_i = 1'b1;
    tick();
    checks++;
    if ({v2, r2, c2, d2} !== {1'b1, 1'b0, 1'b1, 16'hF000}) begin
      errors++;
      $display("FAIL bp_ch1: got v=%b r=%b c=%h d=%h want v=1 r=0 c=1 d=f000", v2, r2, c2, d2);
    end
    tick();
    checks++;
    if ({v2, r2} !== 2'b01) begin
      errors++;
      $display("FAIL bp_done: got v=%b r=%b want v=0 r=1", v2, r2);
    end
  endtask

  // Second frame without reset: accumulators must have been cleared by the drain.
  task automatic test_back_to_back();
    logic [15:0] a [5] = '{default: 16'h0800};
    logic [15:0] b [5] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500};
    send_two_ch(a, b);
    checks++;
    if ({v2, c2, d2} !== {1'b1, 1'b0, 16'h0800}) begin
      errors++;
      $display("FAIL b2b_ch0: got v=%b c=%h d=%h want v=1 c=0 d=0800", v2, c2, d2);
    end
    tick();
    checks++;
    if ({v2, c2, d2} !== {1'b1, 1'b1, 16'h0300}) begin
      errors++;
      $display("FAIL b2b_ch1: got v=%b c=%h d=%h want v=1 c=1 d=0300", v2, c2, d2);
    end
    tick();
  endtask

  task automatic test_full_scale();
    logic [15:0] exp;
`ifdef GAP_SATURATE_EN
    exp = 16'h7FFF;
`else
    exp = 16'h8000;
`endif
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) send(16'h7FFF);
    checks++;
    if ({v6, d6} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL full_scale: got v=%b d=%h want v=1 d=%h", v6, d6, exp);
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) send(16'h7FFF);
    do_reset();
    send(16'h1000);
    tick();
    tick();
    checks++;
    if ({r1, v1} !== 2'b10) begin
      errors++;
      $display("FAIL gap_ready: got r=%b v=%b want r=1 v=0", r1, v1);
    end
    send(16'h1000);
    send(16'h1000);
    tick();
    send(16'h1000);
    send(16'h1000);
    checks++;
    if ({v1, d1} !== {1'b1, 16'h1000}) begin
      errors++;
      $display("FAIL mid_reset_out: got v=%b d=%h want v=1 d=1000", v1, d1);
    end
    tick();
    // Reset while holding an output under backpressure.
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) send(16'h1000);
    do_reset();
    checks++;
    if ({v1, r1, d1} !== {1'b0, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL drain_reset: got v=%b r=%b d=%h want v=0 r=1 d=0000", v1, r1, d1);
    end
    ready_i = 1'b1;
  endtask

  initial begin
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    data_i  = '0;
    test_reset();
    test_single("t1", 16'h1000, 16'h1000);
    test_single("t2", 16'hF000, 16'hF000);
    test_rounding();
    test_two_channel();
    test_backpressure();
    test_back_to_back();
    test_full_scale();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
